// File: rtl/homo_peak_detector_pkg.sv
// Shared types and constants for the homomorphic-envelope peak detector.
// Samples are Q3.12 in the low bits of a signed word.
package homo_peak_detector_pkg;

  localparam int Q_FRAC_BITS = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_REFRACT = 2'd2
  } state_e;

endpackage

// File: rtl/homo_peak_detector.sv
// Finds envelope peaks: one {amplitude, index} record per above-threshold run,
// closed with hysteresis or a width limit, followed by a refractory window.
//
// state   | meaning
// IDLE    | waiting for a sample above THRESHOLD
// ARMED   | inside a run, tracking the largest sample seen
// REFRACT | ignoring samples after an emitted peak
module homo_peak_detector
  import homo_peak_detector_pkg::*;
#(
  parameter int                        DATA_W     = 32,
  parameter int                        CNT_W      = 32,
  parameter logic signed [DATA_W-1:0]  THRESHOLD  = DATA_W'(1 << (Q_FRAC_BITS - 1)),
  parameter logic signed [DATA_W-1:0]  HYST       = DATA_W'(1 << (Q_FRAC_BITS - 4)),
  parameter int                        REFRACTORY = 40,
  parameter int                        MAX_WIDTH  = 64
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  output logic [DATA_W-1:0] m_axis_peak_tdata,
  output logic [CNT_W-1:0]  m_axis_peak_tuser,
  output logic              m_axis_peak_tvalid,
  input  logic              m_axis_peak_tready
);

  localparam logic signed [DATA_W-1:0] DISARM = THRESHOLD - HYST;
  localparam logic [CNT_W-1:0] REFRACT_LD = CNT_W'(REFRACTORY);
  localparam logic [CNT_W-1:0] WIDTH_MAX  = CNT_W'(MAX_WIDTH);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          rcnt_q, rcnt_d;
  logic [CNT_W-1:0]          width_q, width_d;
  logic signed [DATA_W-1:0]  cand_amp_q, cand_amp_d;
  logic [CNT_W-1:0]          cand_idx_q, cand_idx_d;
  logic                      m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]         m_tdata_q, m_tdata_d;
  logic [CNT_W-1:0]          m_tuser_q, m_tuser_d;

  logic                      s_fire;
  logic signed [DATA_W-1:0]  x;

  // A pending record blocks new samples, so an emit can never overwrite one.
  assign s_axis_data_tready = ~areset & (~m_tvalid_q | m_axis_peak_tready);
  assign s_fire             = s_axis_data_tvalid & s_axis_data_tready;
  assign x                  = s_axis_data_tdata;

  assign m_axis_peak_tvalid = m_tvalid_q;
  assign m_axis_peak_tdata  = m_tdata_q;
  assign m_axis_peak_tuser  = m_tuser_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rcnt_d     = rcnt_q;
    width_d    = width_q;
    cand_amp_d = cand_amp_q;
    cand_idx_d = cand_idx_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;

    if (m_tvalid_q && m_axis_peak_tready) m_tvalid_d = 1'b0;

    if (s_fire) begin
      idx_d = idx_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (x > THRESHOLD) begin
            state_d    = ST_ARMED;
            cand_amp_d = x;
            cand_idx_d = idx_q;
            width_d    = CNT_W'(1);
          end
        end
        ST_ARMED: begin
          // The closing sample never competes for the peak.
          if ((x < DISARM) || (width_q == WIDTH_MAX)) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = cand_amp_q;
            m_tuser_d  = cand_idx_q;
            width_d    = '0;
            if (REFRACTORY == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_REFRACT;
              rcnt_d  = REFRACT_LD;
            end
          end else begin
            width_d = width_q + 1'b1;
            if (x > cand_amp_q) begin
              cand_amp_d = x;
              cand_idx_d = idx_q;
            end
          end
        end
        ST_REFRACT: begin
          rcnt_d = rcnt_q - 1'b1;
          if (rcnt_q <= CNT_W'(1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rcnt_q     <= '0;
      width_q    <= '0;
      cand_amp_q <= '0;
      cand_idx_q <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rcnt_q     <= rcnt_d;
      width_q    <= width_d;
      cand_amp_q <= cand_amp_d;
      cand_idx_q <= cand_idx_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
    end
  end

endmodule

// File: tb/tb_homo_peak_detector.sv
// Scoreboard bench for homo_peak_detector: stimulus pushes expected records,
// a negedge monitor pops and compares them on every output handshake.
module tb_homo_peak_detector;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [31:0] m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] amp;
    logic [31:0] idx;
  } rec_t;

  rec_t sb[$];

  always #5 aclk = ~aclk;

  homo_peak_detector #(
    .DATA_W(32), .CNT_W(32),
    .THRESHOLD(32'sh800), .HYST(32'sh100),
    .REFRACTORY(4), .MAX_WIDTH(8)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_peak_tdata  (m_tdata),
    .m_axis_peak_tuser  (m_tuser),
    .m_axis_peak_tvalid (m_tvalid),
    .m_axis_peak_tready (m_tready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rec(input logic [31:0] amp, input logic [31:0] idx);
    rec_t r;
    r.amp = amp;
    r.idx = idx;
    sb.push_back(r);
  endtask

  // Monitor: every output handshake must match the oldest expected record.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got amp 0x%0h idx %0d expected none", m_tdata, m_tuser);
      end else begin
        rec_t r;
        r = sb.pop_front();
        chk("rec_amp", {32'd0, m_tdata}, {32'd0, r.amp});
        chk("rec_idx", {32'd0, m_tuser}, {32'd0, r.idx});
      end
    end
  end

  task automatic send(input logic [31:0] x);
    int n;
    @(negedge aclk);
    s_tdata  = x;
    s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_tready stayed 0 expected 1");
    end
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    #3;
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tready", {63'd0, s_tready}, 64'd0);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] neg;
    neg = -32'sd4096;

    // Reset values
    #7;
    chk("rst_tvalid0", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata0",  {32'd0, m_tdata}, 64'd0);
    chk("rst_tuser0",  {32'd0, m_tuser}, 64'd0);
    chk("rst_tready0", {63'd0, s_tready}, 64'd0);
    @(negedge aclk);
    areset = 1'b0;

    // Basic peak, then refractory window
    expect_rec(32'hC00, 32'd3);
    send(32'h0); send(32'h400); send(32'h900); send(32'hC00); send(32'hA00); send(32'h600);
    @(negedge aclk);
    chk("t1_tvalid_rise", {63'd0, m_tvalid}, 64'd1);
    @(negedge aclk);
    chk("t1_tvalid_fall", {63'd0, m_tvalid}, 64'd0);
    expect_rec(32'hF00, 32'd10);
    repeat (5) send(32'hF00);
    send(32'h0);
    idle(3);

    // Hysteresis: 0x780 sits between disarm and threshold
    do_reset();
    expect_rec(32'hA00, 32'd3);
    send(32'h0); send(32'h900); send(32'h780); send(32'hA00); send(32'h6FF);
    idle(3);

    // Backpressure
    do_reset();
    m_tready = 1'b0;
    expect_rec(32'h900, 32'd0);
    send(32'h900); send(32'h600);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("bp_tvalid", {63'd0, m_tvalid}, 64'd1);
      chk("bp_tready", {63'd0, s_tready}, 64'd0);
      chk("bp_tdata",  {32'd0, m_tdata}, 64'h900);
      chk("bp_tuser",  {32'd0, m_tuser}, 64'd0);
    end
    @(posedge aclk);
    #1 m_tready = 1'b1;
    #1;
    chk("bp_release_tready", {63'd0, s_tready}, 64'd1);
    idle(3);

    // Width limit: ties keep the first sample
    do_reset();
    expect_rec(32'h900, 32'd0);
    repeat (10) send(32'h900);
    idle(3);

    // Async reset while armed discards the candidate
    do_reset();
    send(32'h900); send(32'hC00);
    #3 areset = 1'b1;
    #1;
    chk("async_rst_tready", {63'd0, s_tready}, 64'd0);
    chk("async_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    #4 areset = 1'b0;
    expect_rec(32'hA00, 32'd2);
    send(neg); send(32'h0); send(32'hA00); send(32'h0);
    idle(5);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
